// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, next-PC selection and the IF/ID pipeline register.
// After reset it spends one BOOT cycle loading a bubble, then fetches one word per cycle.
//
// state | meaning
// BOOT  | first edge after reset: PC held at RESET_PC, bubble loaded into IF/ID
// RUN   | normal fetch; stays here until the next reset
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  input  logic        jump_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_data_i,
  output logic [31:0] ifid_instr_o,
  output logic [31:0] ifid_pc4_o,
  output logic        ifid_valid_o,
  output logic [5:0]  instr_op_o,
  output logic [31:0] fetch_count_o
);

  localparam logic [0:0] BOOT = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]  state;
  logic [31:0] pc;
  logic [31:0] pcPlus4;
  logic [31:0] jumpTarget;
  logic [31:0] nextPc;
  logic        takeJump;
  logic        redirect;

  assign imem_addr_o = {pc[31:2], 2'b00};
  assign pcPlus4     = imem_addr_o + 32'd4;
  assign instr_op_o  = ifid_instr_o[31:26];

  // A jump is only meaningful when IF/ID holds a real instruction.
  assign takeJump   = jump_i & ifid_valid_o;
  assign redirect   = branch_taken_i | takeJump;
  assign jumpTarget = {ifid_pc4_o[31:28], ifid_instr_o[25:0], 2'b00};

  always_comb begin
    nextPc = pc;
    if (branch_taken_i) begin
      nextPc = branch_target_i & 32'hFFFF_FFFC;
    end else if (takeJump) begin
      nextPc = jumpTarget;
    end else if (stall_i) begin
      nextPc = pc;
    end else begin
      nextPc = pcPlus4;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= BOOT;
      pc            <= RESET_PC;
      ifid_instr_o  <= 32'd0;
      ifid_pc4_o    <= 32'd0;
      ifid_valid_o  <= 1'b0;
      fetch_count_o <= 32'd0;
    end else if (state == BOOT) begin
      state        <= RUN;
      pc           <= RESET_PC;
      ifid_instr_o <= 32'd0;
      ifid_pc4_o   <= 32'd0;
      ifid_valid_o <= 1'b0;
    end else begin
      pc <= nextPc;
      // Redirect and flush win over stall: the held word is on the wrong path.
      if (redirect || flush_i) begin
        ifid_instr_o <= 32'd0;
        ifid_pc4_o   <= 32'd0;
        ifid_valid_o <= 1'b0;
      end else if (!stall_i) begin
        ifid_instr_o  <= imem_data_i;
        ifid_pc4_o    <= pcPlus4;
        ifid_valid_o  <= 1'b1;
        fetch_count_o <= fetch_count_o + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: expected IF/ID and PC values are queued per step
// and compared one step later against the DUT outputs.
module tb_fetch_stage;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        stall_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        branch_taken_i = 1'b0;
  logic [31:0] branch_target_i = 32'd0;
  logic        jump_i = 1'b0;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_data_i;
  logic [31:0] ifid_instr_o;
  logic [31:0] ifid_pc4_o;
  logic        ifid_valid_o;
  logic [5:0]  instr_op_o;
  logic [31:0] fetch_count_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .stall_i(stall_i),
    .flush_i(flush_i),
    .branch_taken_i(branch_taken_i),
    .branch_target_i(branch_target_i),
    .jump_i(jump_i),
    .imem_addr_o(imem_addr_o),
    .imem_data_i(imem_data_i),
    .ifid_instr_o(ifid_instr_o),
    .ifid_pc4_o(ifid_pc4_o),
    .ifid_valid_o(ifid_valid_o),
    .instr_op_o(instr_op_o),
    .fetch_count_o(fetch_count_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    case (a)
      32'h0000_0000: memWord = 32'h2008_0005;
      32'h0000_0004: memWord = 32'h0800_0040;
      default:       memWord = 32'h8C00_0000 | {6'd0, a[27:2]};
    endcase
  endfunction

  assign imem_data_i = memWord(imem_addr_o);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pushExp(input string tag, input logic [31:0] ePc, input logic [31:0] eInstr,
                         input logic [31:0] ePc4, input logic eValid, input logic [31:0] eCnt);
    exp_t e;
    e.tag = tag; e.pc = ePc; e.instr = eInstr; e.pc4 = ePc4; e.valid = eValid; e.cnt = eCnt;
    sb.push_back(e);
  endtask

  task automatic compareHead();
    exp_t e;
    logic [31:0] opExp;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = sb.pop_front();
      opExp = {26'd0, e.instr[31:26]};
      chk({e.tag, ".pc"},    imem_addr_o, e.pc);
      chk({e.tag, ".instr"}, ifid_instr_o, e.instr);
      chk({e.tag, ".pc4"},   ifid_pc4_o, e.pc4);
      chk({e.tag, ".valid"}, {31'd0, ifid_valid_o}, {31'd0, e.valid});
      chk({e.tag, ".op"},    {26'd0, instr_op_o}, opExp);
      chk({e.tag, ".count"}, fetch_count_o, e.cnt);
    end
  endtask

  task automatic step(input string tag, input logic st, input logic fl, input logic br,
                      input logic [31:0] tgt, input logic jp,
                      input logic [31:0] ePc, input logic [31:0] eInstr,
                      input logic [31:0] ePc4, input logic eValid, input logic [31:0] eCnt);
    stall_i = st;
    flush_i = fl;
    branch_taken_i = br;
    branch_target_i = tgt;
    jump_i = jp;
    pushExp(tag, ePc, eInstr, ePc4, eValid, eCnt);
    @(posedge clk_i);
    #1;
    compareHead();
  endtask

  initial begin
    #1;
    pushExp("reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
    compareHead();
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    //   tag           st fl br target        jp  pc            instr          pc4           v  cnt
    step("boot",       0, 0, 0, 32'h0,        0,  32'h0,        32'h0,         32'h0,        0, 0);
    step("seq0",       0, 0, 0, 32'h0,        0,  32'h4,        32'h2008_0005, 32'h4,        1, 1);
    step("seq1",       0, 0, 0, 32'h0,        0,  32'h8,        32'h0800_0040, 32'h8,        1, 2);
    step("jump",       0, 0, 0, 32'h0,        1,  32'h100,      32'h0,         32'h0,        0, 2);
    step("postJump",   0, 0, 0, 32'h0,        0,  32'h104,      32'h8C00_0040, 32'h104,      1, 3);
    step("branchC",    0, 0, 1, 32'hC,        0,  32'hC,        32'h0,         32'h0,        0, 3);
    step("jumpIgnore", 0, 0, 0, 32'h0,        1,  32'h10,       32'h8C00_0003, 32'h10,       1, 4);
    step("stall1",     1, 0, 0, 32'h0,        0,  32'h10,       32'h8C00_0003, 32'h10,       1, 4);
    step("stall2",     1, 0, 0, 32'h0,        0,  32'h10,       32'h8C00_0003, 32'h10,       1, 4);
    step("stall3",     1, 0, 0, 32'h0,        0,  32'h10,       32'h8C00_0003, 32'h10,       1, 4);
    step("unstall",    0, 0, 0, 32'h0,        0,  32'h14,       32'h8C00_0004, 32'h14,       1, 5);
    step("flush",      0, 1, 0, 32'h0,        0,  32'h18,       32'h0,         32'h0,        0, 5);
    step("flushStall", 1, 1, 0, 32'h0,        0,  32'h18,       32'h0,         32'h0,        0, 5);
    step("seq18",      0, 0, 0, 32'h0,        0,  32'h1C,       32'h8C00_0006, 32'h1C,       1, 6);
    step("simul",      1, 0, 1, 32'h203,      1,  32'h200,      32'h0,         32'h0,        0, 6);
    step("post200",    0, 0, 0, 32'h0,        0,  32'h204,      32'h8C00_0080, 32'h204,      1, 7);
    step("toTop",      0, 0, 1, 32'hFFFF_FFFE,0,  32'hFFFF_FFFC, 32'h0,        32'h0,        0, 7);
    step("wrap",       0, 0, 0, 32'h0,        0,  32'h0,        32'h8FFF_FFFF, 32'h0,        1, 8);
    step("afterWrap",  0, 0, 0, 32'h0,        0,  32'h4,        32'h2008_0005, 32'h4,        1, 9);
    step("branch3C",   0, 0, 1, 32'h3C,       0,  32'h3C,       32'h0,         32'h0,        0, 9);
    step("at40",       0, 0, 0, 32'h0,        0,  32'h40,       32'h8C00_000F, 32'h40,       1, 10);

    // Mid-cycle reset with a stall, flush and branch all pending.
    stall_i = 1'b1;
    flush_i = 1'b1;
    branch_taken_i = 1'b1;
    branch_target_i = 32'h80;
    #2;
    rst_i = 1'b1;
    pushExp("asyncRst", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
    #1;
    compareHead();
    stall_i = 1'b0;
    flush_i = 1'b0;
    branch_taken_i = 1'b0;
    branch_target_i = 32'h0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    step("reboot",     0, 0, 0, 32'h0,        0,  32'h0,        32'h0,         32'h0,        0, 0);
    step("reseq0",     0, 0, 0, 32'h0,        0,  32'h4,        32'h2008_0005, 32'h4,        1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL provide port clk_i  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL provide port rst_i  input  1  reset, asynchronous and active-high.
REQ-004 SHALL provide port stall_i  input  1  hazard stall; hold PC and IF/ID contents.
REQ-005 SHALL provide port flush_i  input  1  squash IF/ID contents to a bubble.
REQ-006 SHALL provide port branch_taken_i  input  1  resolved taken branch from the EX stage.
REQ-007 SHALL provide port branch_target_i  input  32  branch destination address.
REQ-008 SHALL provide port jump_i  input  1  Jump control from the decoder for the instruction held in IF/ID.
REQ-009 SHALL provide port imem_addr_o  output  32  instruction memory address (current PC).
REQ-010 SHALL provide port imem_data_i  input  32  instruction word; combinational read of imem_addr_o.
REQ-011 SHALL provide port ifid_instr_o  output  32  registered instruction for the decode stage.
REQ-012 SHALL provide port ifid_pc4_o  output  32  registered PC+4 of ifid_instr_o.
REQ-013 SHALL provide port ifid_valid_o  output  1  IF/ID holds a real instruction, not a bubble.
REQ-014 SHALL provide port instr_op_o  output  6  ifid_instr_o[31:26]; drives the decoder opcode input.
REQ-015 SHALL provide port fetch_count_o  output  32  count of valid instructions loaded into IF/ID.

Function
REQ-016 SHALL implement FSM states BOOT and RUN: BOOT is entered on reset; BOOT->RUN unconditionally on the first clock edge after reset release; RUN persists until the next reset.
REQ-017 SHALL, in BOOT, hold the PC at RESET_PC and load a bubble into IF/ID.
REQ-018 SHALL drive imem_addr_o = PC combinationally, with bits [1:0] always 0.
REQ-019 SHALL, in RUN, select the next PC with priority: branch_taken_i -> branch_target_i; else jump_i and ifid_valid_o -> {ifid_pc4_o[31:28], ifid_instr_o[25:0], 2'b00}; else stall_i -> hold; else PC+4.
REQ-020 SHALL force redirect targets to word alignment by clearing bits [1:0].
REQ-021 SHALL compute PC+4 modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-022 SHALL load a bubble into IF/ID (instr 0, pc4 0, valid 0) on any redirect or on flush_i; redirect and flush override stall_i.
REQ-023 SHALL, with no redirect or flush, hold IF/ID unchanged while stall_i is 1.
REQ-024 SHALL, otherwise, load IF/ID with instr=imem_data_i, pc4=PC+4, valid=1.
REQ-025 SHALL ignore jump_i when ifid_valid_o is 0.
REQ-026 SHALL produce fetch latency of exactly one cycle: a word addressed in cycle N appears on ifid_instr_o in cycle N+1.
REQ-027 SHALL increment fetch_count_o by 1 on each edge that loads a valid instruction into IF/ID; it wraps from 32'hFFFF_FFFF to 0.

Reset
REQ-028 SHALL, on rst_i=1 and independent of clk_i: PC=RESET_PC, state=BOOT, ifid_instr_o=0, ifid_pc4_o=0, ifid_valid_o=0, fetch_count_o=0, and therefore instr_op_o=0.
REQ-029 SHALL, on reset asserted mid-operation, discard any pending stall, flush or redirect, and restart from REQ-016 after release.

Verification
REQ-030 SHALL cover sequential fetch: reset, then release; memory holds 0x20080005 at address 0 -> cycle 1 bubble (BOOT); cycle 2 ifid_instr_o=0x20080005, ifid_pc4_o=4, instr_op_o=8, fetch_count_o=1.
REQ-031 SHALL cover stall: assert stall_i for 3 cycles at PC=0x10 -> imem_addr_o stays 0x10 and IF/ID is unchanged; after release, PC=0x14 on the next edge.
REQ-032 SHALL cover jump: IF/ID holds 0x08000040 with ifid_pc4_o=0x8, jump_i=1 -> next PC=0x100; IF/ID becomes a bubble; fetch_count_o does not increment.
REQ-033 SHALL cover simultaneous events: branch_taken_i=1 (target 0x203), jump_i=1 and stall_i=1 in the same cycle -> next PC=0x200; IF/ID becomes a bubble.
REQ-034 SHALL cover wrap-around: PC=0xFFFF_FFFC with no control inputs asserted -> next PC=0; ifid_pc4_o=0.
REQ-035 SHALL cover asynchronous reset: assert rst_i mid-cycle at PC=0x40 -> PC=RESET_PC and all outputs are zero before the next clock edge.
